// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter: one word per grant,
// sent as start / DBIT data bits LSB first / stop, timed by the oversampling tick.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 frame_done
);
    localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int TCW  = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [TCW-1:0]    tc_r, tc_s;
    logic [NW-1:0]     n_r, n_s;
    logic [DBIT-1:0]   shreg_r, shreg_s;
    logic [IDW-1:0]    last_r, last_s;
    logic [IDW-1:0]    gid_r, gid_s;
    logic [NREQ-1:0]   ready_r, ready_s;
    logic              tx_r, tx_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              found_s;
    logic [IDW-1:0]    pick_s;
    logic [IDW-1:0]    cand_s;

    assign req_ready  = ready_r;
    assign tx         = tx_r;
    assign busy       = busy_r;
    assign grant_id   = gid_r;
    assign frame_done = done_r;

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_s = state_r;
        tc_s    = tc_r;
        n_s     = n_r;
        shreg_s = shreg_r;
        last_s  = last_r;
        gid_s   = gid_r;
        ready_s = '0;
        done_s  = 1'b0;
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;

        // first valid requester after the last one granted, wrapping at NREQ
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDW'((int'(last_r) + k) % NREQ);
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end

        case (state_r)
            IDLE: begin
                if (found_s) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_s == IDW'(i)) begin
                            ready_s[i] = 1'b1;
                            shreg_s    = req_data[i*DBIT +: DBIT];
                        end else begin
                            ready_s[i] = 1'b0;
                        end
                    end
                    gid_s   = pick_s;
                    last_s  = pick_s;
                    tc_s    = '0;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tc_r == TCW'(OVS - 1)) begin
                        tc_s    = '0;
                        n_s     = '0;
                        state_s = DATA;
                    end else begin
                        tc_s = tc_r + TCW'(1);
                    end
                end else begin
                    tc_s = tc_r;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tc_r == TCW'(OVS - 1)) begin
                        tc_s    = '0;
                        shreg_s = {1'b0, shreg_r[DBIT-1:1]};
                        if (n_r == NW'(DBIT - 1)) begin
                            state_s = STOP;
                        end else begin
                            n_s = n_r + NW'(1);
                        end
                    end else begin
                        tc_s = tc_r + TCW'(1);
                    end
                end else begin
                    tc_s = tc_r;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tc_r == TCW'(SB_TICK - 1)) begin
                        tc_s    = '0;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        tc_s = tc_r + TCW'(1);
                    end
                end else begin
                    tc_s = tc_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // line level follows the state being entered so tx is a clean register
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shreg_s[0];
            default: tx_s = 1'b1;
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs; reset abandons any frame and idles the line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            tc_r    <= '0;
            n_r     <= '0;
            shreg_r <= '0;
            last_r  <= IDW'(NREQ - 1);
            gid_r   <= '0;
            ready_r <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tc_r    <= tc_s;
            n_r     <= n_s;
            shreg_r <= shreg_s;
            last_r  <= last_s;
            gid_r   <= gid_s;
            ready_r <= ready_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end
endmodule
